// File: rtl/memaccess_pkg.sv
// Shared opcode, instruction-field and state definitions for the memory-access stage.
package memaccess_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_NOP  = 4'hF;

    // Bubble instruction: an opcode that decodes as none of the ALU ops or LW.
    localparam logic [15:0] NOP_IR = {OP_NOP, 12'h000};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic [3:0] get_op(input logic [15:0] ir);
        return ir[15:12];
    endfunction

endpackage

// File: rtl/memaccess.sv
// Memory-access pipeline stage: passes ALU results through, and stalls upstream
// while an LW/SW waits for the data-memory ack, aborting after TMO cycles.
//
// state | meaning
// IDLE  | accept a bundle each cycle; LW/SW are latched and start a memory access
// WAIT  | memory request held; STALL high until DM_ACK or timeout
module memaccess
    import memaccess_pkg::*;
#(
    parameter int unsigned TMO = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] IRIN,
    input  logic [15:0] ALUIN,
    input  logic [15:0] STDATAIN,
    input  logic [3:0]  DSTIN,
    input  logic        VALIDIN,
    output logic        STALL,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [15:0] DM_ADDR,
    output logic [15:0] DM_WDATA,
    input  logic [15:0] DM_RDATA,
    input  logic        DM_ACK,
    output logic [15:0] IROUT,
    output logic [15:0] DATAOUT,
    output logic [15:0] ADDROUT,
    output logic        ERR
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] hold_ir, hold_ir_n, hold_alu, hold_alu_n, hold_st, hold_st_n;
    logic [3:0]  hold_dst, hold_dst_n;
    logic [15:0] ir_n, data_n, addr_n, dm_addr_n, dm_wdata_n;
    logic        dm_req_n, dm_we_n, err_n;
    logic [3:0]  op_in;

    assign op_in = get_op(IRIN);
    assign STALL = (state == WAIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            hold_ir  <= '0;
            hold_alu <= '0;
            hold_st  <= '0;
            hold_dst <= '0;
            IROUT    <= NOP_IR;
            DATAOUT  <= '0;
            ADDROUT  <= '0;
            DM_REQ   <= 1'b0;
            DM_WE    <= 1'b0;
            DM_ADDR  <= '0;
            DM_WDATA <= '0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hold_ir  <= hold_ir_n;
            hold_alu <= hold_alu_n;
            hold_st  <= hold_st_n;
            hold_dst <= hold_dst_n;
            IROUT    <= ir_n;
            DATAOUT  <= data_n;
            ADDROUT  <= addr_n;
            DM_REQ   <= dm_req_n;
            DM_WE    <= dm_we_n;
            DM_ADDR  <= dm_addr_n;
            DM_WDATA <= dm_wdata_n;
            ERR      <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hold_ir_n  = hold_ir;
        hold_alu_n = hold_alu;
        hold_st_n  = hold_st;
        hold_dst_n = hold_dst;
        ir_n       = NOP_IR;
        data_n     = '0;
        addr_n     = '0;
        dm_req_n   = 1'b0;
        dm_we_n    = 1'b0;
        dm_addr_n  = '0;
        dm_wdata_n = '0;
        err_n      = ERR;
        case (state)
            IDLE: begin
                if (VALIDIN) begin
                    if (op_in == OP_LW || op_in == OP_SW) begin
                        state_n    = WAIT;
                        cnt_n      = '0;
                        hold_ir_n  = IRIN;
                        hold_alu_n = ALUIN;
                        hold_st_n  = STDATAIN;
                        hold_dst_n = DSTIN;
                        dm_req_n   = 1'b1;
                        dm_we_n    = (op_in == OP_SW);
                        dm_addr_n  = ALUIN;
                        dm_wdata_n = (op_in == OP_SW) ? STDATAIN : 16'h0000;
                    end else begin
                        ir_n   = IRIN;
                        data_n = ALUIN;
                        addr_n = {12'b0, DSTIN};
                    end
                end
            end
            WAIT: begin
                // Ack is checked first so a same-cycle timeout cannot flag ERR.
                if (DM_ACK) begin
                    state_n = IDLE;
                    ir_n    = hold_ir;
                    addr_n  = {12'b0, hold_dst};
                    data_n  = (get_op(hold_ir) == OP_LW) ? DM_RDATA : hold_alu;
                end else if (cnt == TMO_LAST) begin
                    state_n    = IDLE;
                    err_n      = 1'b1;
                    hold_ir_n  = '0;
                    hold_alu_n = '0;
                    hold_st_n  = '0;
                    hold_dst_n = '0;
                end else begin
                    cnt_n      = cnt + 8'd1;
                    dm_req_n   = DM_REQ;
                    dm_we_n    = DM_WE;
                    dm_addr_n  = DM_ADDR;
                    dm_wdata_n = DM_WDATA;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memaccess.sv
// Randomized bench for memaccess: transaction-level expectations of each bundle,
// stall window, memory request and sticky error, plus directed corner cases.
module tb_memaccess;
    import memaccess_pkg::*;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] IRIN = '0, ALUIN = '0, STDATAIN = '0, DM_RDATA = '0;
    logic [3:0]  DSTIN = '0;
    logic        VALIDIN = 1'b0, DM_ACK = 1'b0;
    logic        STALL, DM_REQ, DM_WE, ERR;
    logic [15:0] DM_ADDR, DM_WDATA, IROUT, DATAOUT, ADDROUT;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_err = 1'b0;

    memaccess #(.TMO(TMO)) dut (
        .CLK(CLK), .RST(RST), .IRIN(IRIN), .ALUIN(ALUIN), .STDATAIN(STDATAIN),
        .DSTIN(DSTIN), .VALIDIN(VALIDIN), .STALL(STALL), .DM_REQ(DM_REQ),
        .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_RDATA(DM_RDATA),
        .DM_ACK(DM_ACK), .IROUT(IROUT), .DATAOUT(DATAOUT), .ADDROUT(ADDROUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [15:0] ir, input logic [15:0] data,
                              input logic [15:0] addr, input logic stall, input logic req,
                              input logic we, input logic [15:0] daddr, input logic [15:0] wdata);
        check({tag, ".IROUT"}, IROUT, ir);
        check({tag, ".DATAOUT"}, DATAOUT, data);
        check({tag, ".ADDROUT"}, ADDROUT, addr);
        check({tag, ".STALL"}, {15'b0, STALL}, {15'b0, stall});
        check({tag, ".DM_REQ"}, {15'b0, DM_REQ}, {15'b0, req});
        check({tag, ".DM_WE"}, {15'b0, DM_WE}, {15'b0, we});
        check({tag, ".DM_ADDR"}, DM_ADDR, daddr);
        check({tag, ".DM_WDATA"}, DM_WDATA, wdata);
        check({tag, ".ERR"}, {15'b0, ERR}, {15'b0, exp_err});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bubble();
        IRIN = 16'($urandom); ALUIN = 16'($urandom); DSTIN = 4'($urandom);
        VALIDIN = 1'b0; DM_ACK = 1'($urandom); DM_RDATA = 16'($urandom);
        tick();
        expect_out("bubble", NOP_IR, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // lat = WAIT cycle index (0-based) on which the memory acks; lat >= TMO never acks.
    task automatic run_instr(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] st,
                             input logic [3:0] dst, input int lat, input logic [15:0] rdata);
        logic [15:0] ir;
        logic is_mem, is_sw;
        ir = {op, 12'($urandom)};
        is_sw  = (op == OP_SW);
        is_mem = (op == OP_LW) || is_sw;
        IRIN = ir; ALUIN = alu; STDATAIN = st; DSTIN = dst; VALIDIN = 1'b1;
        DM_ACK = 1'($urandom); DM_RDATA = 16'($urandom);
        tick();
        if (!is_mem) begin
            expect_out("alu", ir, alu, {12'b0, dst}, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            return;
        end
        expect_out("capture", NOP_IR, 16'h0, 16'h0, 1'b1, 1'b1, is_sw, alu, is_sw ? st : 16'h0);
        for (int k = 0; k < TMO; k++) begin
            IRIN = 16'($urandom); ALUIN = 16'($urandom); STDATAIN = 16'($urandom);
            DSTIN = 4'($urandom); VALIDIN = 1'($urandom);
            DM_ACK = (k == lat);
            DM_RDATA = (k == lat) ? rdata : 16'($urandom);
            tick();
            if (k == lat) begin
                expect_out("ack", ir, is_sw ? alu : rdata, {12'b0, dst},
                           1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                return;
            end
            if (k == TMO - 1) begin
                exp_err = 1'b1;
                expect_out("timeout", NOP_IR, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                return;
            end
            expect_out("wait", NOP_IR, 16'h0, 16'h0, 1'b1, 1'b1, is_sw, alu, is_sw ? st : 16'h0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [6];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_OR;
        ops[3] = OP_AND; ops[4] = OP_SLT; ops[5] = OP_ADDI;

        #12;
        expect_out("reset", NOP_IR, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge CLK); #1;
        RST = 1'b0;

        bubble();
        run_instr(OP_ADD, 16'h0005, 16'h0, 4'd3, 0, 16'h0);
        run_instr(OP_LW, 16'h0040, 16'h0, 4'd7, 2, 16'hBEEF);
        run_instr(OP_SW, 16'h0010, 16'h1234, 4'd2, 0, 16'h0);
        run_instr(OP_LW, 16'h0022, 16'h0, 4'd1, TMO - 1, 16'hCAFE);
        run_instr(OP_LW, 16'h0033, 16'h0, 4'd5, TMO + 3, 16'h0);
        run_instr(OP_ADD, 16'h0101, 16'h0, 4'd9, 0, 16'h0);

        // Reset in the second WAIT cycle aborts the access; a late ack is ignored.
        IRIN = {OP_LW, 12'h0AB}; ALUIN = 16'h0050; DSTIN = 4'd4; VALIDIN = 1'b1; DM_ACK = 1'b0;
        tick();
        VALIDIN = 1'b0;
        tick();
        #2 RST = 1'b1;
        #1;
        exp_err = 1'b0;
        expect_out("rst_wait", NOP_IR, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 RST = 1'b0;
        DM_ACK = 1'b1; DM_RDATA = 16'h5555;
        tick();
        expect_out("late_ack", NOP_IR, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = $urandom_range(0, 8);
            if (sel < 6)
                run_instr(ops[sel], 16'($urandom), 16'($urandom), 4'($urandom), 0, 16'h0);
            else if (sel == 6)
                run_instr(OP_LW, 16'($urandom), 16'($urandom), 4'($urandom),
                          $urandom_range(0, TMO + 1), 16'($urandom));
            else if (sel == 7)
                run_instr(OP_SW, 16'($urandom), 16'($urandom), 4'($urandom),
                          $urandom_range(0, TMO + 1), 16'($urandom));
            else
                bubble();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
